// File: rtl/stream_exerciser.sv
// Stream exerciser: drives an incrementing word sequence into a stage under test and
// checks that the stage's output equals each input word plus INC. Bubbles, stalls and a watchdog are included.
module stream_exerciser #(
    parameter int unsigned COUNT   = 256,
    parameter logic [31:0] INC     = 32'd1,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        gap_en,
    input  logic        stall_en,
    input  logic [31:0] base,
    output logic        tx_val,
    output logic [31:0] tx_data,
    input  logic        tx_rdy,
    input  logic        rx_val,
    input  logic [31:0] rx_data,
    output logic        rx_rdy,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_cnt,
    output logic [15:0] rx_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int          WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [15:0] COUNT_C   = 16'(COUNT);
    localparam logic [WD_W-1:0] TIMEOUT_C = WD_W'(TIMEOUT);

    logic [1:0]      state_q,   state_d;
    logic            tx_val_q,  tx_val_d;
    logic [31:0]     tx_data_q, tx_data_d;
    logic [15:0]     tx_cnt_q,  tx_cnt_d;
    logic [15:0]     rx_cnt_q,  rx_cnt_d;
    logic [15:0]     err_cnt_q, err_cnt_d;
    logic [31:0]     exp_q,     exp_d;
    logic [15:0]     lfsr_q,    lfsr_d;
    logic [WD_W-1:0] wd_q,      wd_d;
    logic            timeout_q, timeout_d;
    logic            rx_rdy_q,  rx_rdy_d;

    logic tx_fire, rx_fire, active, start_ok, lfsr_fb;

    assign tx_fire  = tx_val_q && tx_rdy;
    assign rx_fire  = rx_val && rx_rdy_q;
    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path infers a latch.
        state_d   = state_q;
        tx_val_d  = tx_val_q;
        tx_data_d = tx_data_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        err_cnt_d = err_cnt_q;
        exp_d     = exp_q;
        lfsr_d    = lfsr_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;

        if (start_ok) begin
            state_d   = S_RUN;
            tx_val_d  = 1'b0;
            tx_data_d = base;
            tx_cnt_d  = '0;
            rx_cnt_d  = '0;
            err_cnt_d = '0;
            exp_d     = base + INC;
            lfsr_d    = SEED;
            wd_d      = '0;
            timeout_d = 1'b0;
        end else if (active) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
            if (rx_fire) begin
                rx_cnt_d = rx_cnt_q + 16'd1;
                exp_d    = exp_q + 32'd1;
                if (rx_data != exp_q && err_cnt_q != 16'hFFFF)
                    err_cnt_d = err_cnt_q + 16'd1;
            end
            if (tx_fire) begin
                tx_data_d = tx_data_q + 32'd1;
                tx_cnt_d  = tx_cnt_q + 16'd1;
            end
            if (state_q == S_RUN) begin
                if (tx_fire && tx_cnt_d == COUNT_C) begin
                    state_d  = S_DRAIN;
                    tx_val_d = 1'b0;
                end else if (!tx_val_q || tx_fire) begin
                    tx_val_d = !(gap_en && lfsr_q[0]);
                end
            end else if (rx_cnt_d == COUNT_C) begin
                state_d = S_DONE;
            end
            wd_d = (tx_fire || rx_fire) ? '0 : wd_q + WD_W'(1);
            if (wd_d == TIMEOUT_C) begin
                timeout_d = 1'b1;
                state_d   = S_DONE;
                tx_val_d  = 1'b0;
            end
        end

        // Sink readiness is closed once the last expected word has been counted.
        rx_rdy_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) && (rx_cnt_d != COUNT_C)
                   && !(stall_en && lfsr_d[1]);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tx_val_q  <= 1'b0;
            tx_data_q <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            exp_q     <= '0;
            lfsr_q    <= SEED;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            rx_rdy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_val_q  <= tx_val_d;
            tx_data_q <= tx_data_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            err_cnt_q <= err_cnt_d;
            exp_q     <= exp_d;
            lfsr_q    <= lfsr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            rx_rdy_q  <= rx_rdy_d;
        end
    end

    assign tx_val  = tx_val_q;
    assign tx_data = tx_data_q;
    assign rx_rdy  = rx_rdy_q;
    assign busy    = active;
    assign done    = (state_q == S_DONE);
    assign timeout = timeout_q;
    assign err_cnt = err_cnt_q;
    assign rx_cnt  = rx_cnt_q;
    assign pass    = done && (err_cnt_q == 16'd0) && (rx_cnt_q == COUNT_C) && !timeout_q;

endmodule

// File: tb/tb_stream_exerciser.sv
// Scoreboard bench: instance A (COUNT=4, TIMEOUT=16) runs against a one-deep register stage;
// instance B (COUNT=256) runs against a pass-through stage with toggling ready.
module tb_stream_exerciser;

    typedef struct packed {
        logic        tx_val;
        logic        tx_rdy;
        logic [31:0] tx_data;
        logic        rx_rdy;
        logic        busy;
        logic        done;
        logic        pass;
        logic        timeout;
        logic [15:0] err;
        logic [15:0] rxc;
    } obs_t;

    typedef struct {
        logic pass;
        logic to;
        int   err;
        int   rx;
        int   ntx;
        int   idle;   // -1: idle-run length not checked
    } status_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A signals
    logic        start_a, gap_a, stall_a;
    logic [31:0] base_a;
    logic        tx_val_a, tx_rdy_a, rx_val_a, rx_rdy_a;
    logic [31:0] tx_data_a, rx_data_a;
    logic        busy_a, done_a, pass_a, to_a;
    logic [15:0] err_a, rxc_a;

    // Instance B signals
    logic        start_b, gap_b, stall_b;
    logic [31:0] base_b;
    logic        tx_val_b, tx_rdy_b, rx_val_b, rx_rdy_b;
    logic [31:0] tx_data_b, rx_data_b;
    logic        busy_b, done_b, pass_b, to_b;
    logic [15:0] err_b, rxc_b;

    stream_exerciser #(.COUNT(4), .INC(32'd1), .SEED(16'hACE1), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gap_en(gap_a), .stall_en(stall_a),
        .base(base_a), .tx_val(tx_val_a), .tx_data(tx_data_a), .tx_rdy(tx_rdy_a),
        .rx_val(rx_val_a), .rx_data(rx_data_a), .rx_rdy(rx_rdy_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .timeout(to_a), .err_cnt(err_a), .rx_cnt(rxc_a)
    );

    stream_exerciser #(.COUNT(256)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gap_en(gap_b), .stall_en(stall_b),
        .base(base_b), .tx_val(tx_val_b), .tx_data(tx_data_b), .tx_rdy(tx_rdy_b),
        .rx_val(rx_val_b), .rx_data(rx_data_b), .rx_rdy(rx_rdy_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .timeout(to_b), .err_cnt(err_b), .rx_cnt(rxc_b)
    );

    // One-deep +1 stage for A, with optional corruption of word 2 and rx drop after 3 words.
    logic        s_full, corrupt_en, drop_en, stage_clr;
    logic [31:0] s_data;
    logic [7:0]  s_idx;
    assign rx_val_a  = s_full && !(drop_en && s_idx >= 8'd3);
    assign rx_data_a = s_data ^ {31'd0, corrupt_en && s_idx == 8'd2};
    assign tx_rdy_a  = !s_full || (rx_val_a && rx_rdy_a);
    always @(posedge clk) begin
        if (!rst_n || stage_clr) begin
            s_full <= 1'b0;
            s_data <= '0;
            s_idx  <= '0;
        end else begin
            if (tx_val_a && tx_rdy_a) begin
                s_full <= 1'b1;
                s_data <= tx_data_a + 32'd1;
            end else if (rx_val_a && rx_rdy_a) begin
                s_full <= 1'b0;
            end
            if (rx_val_a && rx_rdy_a) s_idx <= s_idx + 8'd1;
        end
    end

    // Zero-latency +1 stage for B; its ready toggles every cycle.
    logic tog;
    always @(posedge clk) tog <= !rst_n ? 1'b0 : ~tog;
    assign tx_rdy_b  = rx_rdy_b && tog;
    assign rx_val_b  = tx_val_b && tog;
    assign rx_data_b = tx_data_b + 32'd1;

    obs_t ob [2];
    assign ob[0] = '{tx_val: tx_val_a, tx_rdy: tx_rdy_a, tx_data: tx_data_a, rx_rdy: rx_rdy_a,
                     busy: busy_a, done: done_a, pass: pass_a, timeout: to_a, err: err_a, rxc: rxc_a};
    assign ob[1] = '{tx_val: tx_val_b, tx_rdy: tx_rdy_b, tx_data: tx_data_b, rx_rdy: rx_rdy_b,
                     busy: busy_b, done: done_b, pass: pass_b, timeout: to_b, err: err_b, rxc: rxc_b};

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_tx [2][$];
    status_t     exp_st [2][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got expired/empty want event", name);
    endtask

    // Monitor state
    logic        hold   [2];
    logic [31:0] held   [2];
    logic        busy_p [2];
    logic        done_p [2];
    int          ntx    [2];
    int          idle   [2];

    task automatic mon(input int id);
        obs_t        o;
        status_t     s;
        logic [31:0] w;
        logic        fire;
        o = ob[id];
        if (!rst_n) begin
            hold[id]   = 1'b0;
            busy_p[id] = 1'b0;
            done_p[id] = 1'b0;
            return;
        end
        if (o.busy && !busy_p[id]) begin
            ntx[id]  = 0;
            idle[id] = 0;
        end
        if (hold[id]) begin
            check("tx_hold_val", 32'(o.tx_val), 32'd1);
            check("tx_hold_data", o.tx_data, held[id]);
        end
        hold[id] = o.tx_val && !o.tx_rdy;
        held[id] = o.tx_data;
        if (o.tx_val && o.tx_rdy) begin
            ntx[id]++;
            if (exp_tx[id].size() == 0) fail("tx_extra");
            else begin
                w = exp_tx[id].pop_front();
                check("tx_data", o.tx_data, w);
            end
        end
        // rx handshake: A's stage and B's stage expose rx_val via the DUT-facing nets
        fire = (o.tx_val && o.tx_rdy) || (id == 0 ? (rx_val_a && rx_rdy_a) : (rx_val_b && rx_rdy_b));
        if (o.busy) idle[id] = fire ? 0 : idle[id] + 1;
        if (o.done && !done_p[id]) begin
            if (exp_st[id].size() == 0) fail("status_extra");
            else begin
                s = exp_st[id].pop_front();
                check("pass", 32'(o.pass), 32'(s.pass));
                check("timeout", 32'(o.timeout), 32'(s.to));
                check("err_cnt", 32'(o.err), s.err);
                check("rx_cnt", 32'(o.rxc), s.rx);
                check("tx_count", ntx[id], s.ntx);
                check("done_tx_val", 32'(o.tx_val), 32'd0);
                check("done_rx_rdy", 32'(o.rx_rdy), 32'd0);
                if (s.idle >= 0) check("wd_idle", idle[id], s.idle);
            end
        end
        done_p[id] = o.done;
        busy_p[id] = o.busy;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic check_reset(input int id);
        check("rst_tx_val", 32'(ob[id].tx_val), 32'd0);
        check("rst_tx_data", ob[id].tx_data, 32'd0);
        check("rst_rx_rdy", 32'(ob[id].rx_rdy), 32'd0);
        check("rst_busy", 32'(ob[id].busy), 32'd0);
        check("rst_done", 32'(ob[id].done), 32'd0);
        check("rst_pass", 32'(ob[id].pass), 32'd0);
        check("rst_timeout", 32'(ob[id].timeout), 32'd0);
        check("rst_err_cnt", 32'(ob[id].err), 32'd0);
        check("rst_rx_cnt", 32'(ob[id].rxc), 32'd0);
    endtask

    task automatic wait_done(input int id, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ob[id].done) return;
        end
        fail("done_bound");
    endtask

    task automatic pulse_start_a(input logic [31:0] b);
        base_a = b;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic run_a(input logic [31:0] b, input logic g, input logic st, input logic cor,
                         input logic drp, input logic mid_start, input status_t es);
        @(posedge clk); #1 stage_clr = 1'b1;
        @(posedge clk); #1 stage_clr = 1'b0;
        gap_a = g; stall_a = st; corrupt_en = cor; drop_en = drp;
        for (int i = 0; i < 4; i++) exp_tx[0].push_back(b + 32'(i));
        exp_st[0].push_back(es);
        pulse_start_a(b);
        if (mid_start) begin
            repeat (2) @(posedge clk);
            #1 pulse_start_a(32'h0000_0055);
        end
        wait_done(0, 200);
        @(posedge clk); #1;
        check("tx_left", exp_tx[0].size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stage_clr = 1'b0; corrupt_en = 1'b0; drop_en = 1'b0;
        start_a = 1'b0; gap_a = 1'b0; stall_a = 1'b0; base_a = '0;
        start_b = 1'b0; gap_b = 1'b0; stall_b = 1'b0; base_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_tx_val", 32'(tx_val_a), 32'd0);
            check("idle_rx_rdy", 32'(rx_rdy_a), 32'd0);
        end

        run_a(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 0, 4, 4, -1});
        run_a(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '{1'b1, 1'b0, 0, 4, 4, -1});
        run_a(32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 0, 4, 4, -1});
        run_a(32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '{1'b0, 1'b0, 1, 4, 4, -1});
        run_a(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '{1'b0, 1'b1, 0, 3, 4, 16});
        run_a(32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 0, 4, 4, -1});

        // Reset in the middle of a run, then a clean run.
        @(posedge clk); #1 stage_clr = 1'b1;
        @(posedge clk); #1 stage_clr = 1'b0;
        corrupt_en = 1'b0; drop_en = 1'b0;
        for (int i = 0; i < 4; i++) exp_tx[0].push_back(32'(i));
        pulse_start_a(32'h0000_0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset(0);
        rst_n = 1'b1;
        exp_tx[0].delete();
        run_a(32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{1'b1, 1'b0, 0, 4, 4, -1});

        // Long run with bubbles, stalls and toggling stage ready.
        for (int i = 0; i < 256; i++) exp_tx[1].push_back(32'h1000_0000 + 32'(i));
        exp_st[1].push_back('{1'b1, 1'b0, 0, 256, 256, -1});
        gap_b = 1'b1; stall_b = 1'b1; base_b = 32'h1000_0000;
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        wait_done(1, 20000);
        @(posedge clk); #1;
        check("tx_left_b", exp_tx[1].size(), 32'd0);
        check("status_left", exp_st[0].size() + exp_st[1].size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
